// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j, bltz, nori, balrz).
// Moore outputs are registered alongside the state; condition-dependent enables are resolved combinationally.
module multicycle_main_control #(
  parameter logic [5:0] OP_BLTZ     = 6'b000001,
  parameter logic [5:0] OP_NORI     = 6'b010011,
  parameter logic [5:0] FUNCT_BALRZ = 6'b010110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       neg,
  input  logic       rs_zero,
  output logic       aluop1,
  output logic       aluop0,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] pcsource,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_BLTZ   = 4'd10,
    S_JUMP   = 4'd11,
    S_NORIEX = 4'd12,
    S_NORIWB = 4'd13,
    S_BALRZ  = 4'd14,
    S_UNUSED = 4'd15
  } state_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsource;
    logic       pc_en;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   decode_illegal;
  logic   pc_en_cond;
  logic   regwrite_cond;

  always_comb begin
    state_d        = S_FETCH;
    decode_illegal = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          state_d = (funct == FUNCT_BALRZ) ? S_BALRZ : S_REXEC;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BEQ;
        end else if (opcode == OP_BLTZ) begin
          state_d = S_BLTZ;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
        end else if (opcode == OP_NORI) begin
          state_d = S_NORIEX;
        end else begin
          decode_illegal = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_REXEC:  state_d = S_RWB;
      S_NORIEX: state_d = S_NORIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Decode the Moore outputs of the state being entered so they line up with state_q.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.memread = 1'b1;
        ctrl_d.irwrite = 1'b1;
        ctrl_d.alusrcb = 2'b01;
        ctrl_d.pc_en   = 1'b1;
      end
      S_DECODE: ctrl_d.alusrcb = 2'b11;
      S_MEMADR: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        ctrl_d.memread = 1'b1;
        ctrl_d.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.memtoreg = 2'b01;
      end
      S_MEMWR: begin
        ctrl_d.memwrite = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_REXEC: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.aluop   = 2'b10;
      end
      S_RWB: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.regdst   = 1'b1;
      end
      S_BEQ, S_BLTZ: begin
        ctrl_d.alusrca  = 1'b1;
        ctrl_d.aluop    = 2'b01;
        ctrl_d.pcsource = 2'b01;
      end
      S_JUMP: begin
        ctrl_d.pcsource = 2'b10;
        ctrl_d.pc_en    = 1'b1;
      end
      S_NORIEX: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.alusrcb = 2'b10;
        ctrl_d.aluop   = 2'b11;
      end
      S_NORIWB: ctrl_d.regwrite = 1'b1;
      S_BALRZ: begin
        ctrl_d.regdst   = 1'b1;
        ctrl_d.memtoreg = 2'b10;
        ctrl_d.pcsource = 2'b11;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Branch and balrz enables follow the current-cycle condition inputs.
  assign pc_en_cond    = ((state_q == S_BEQ)   && zero) ||
                         ((state_q == S_BLTZ)  && neg)  ||
                         ((state_q == S_BALRZ) && rs_zero);
  assign regwrite_cond = (state_q == S_BALRZ) && rs_zero;

  assign aluop1     = ctrl_q.aluop[1];
  assign aluop0     = ctrl_q.aluop[0];
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign iord       = ctrl_q.iord;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign pcsource   = ctrl_q.pcsource;
  assign memread    = rst_n && ctrl_q.memread;
  assign memwrite   = rst_n && ctrl_q.memwrite;
  assign irwrite    = rst_n && ctrl_q.irwrite;
  assign regwrite   = rst_n && (ctrl_q.regwrite || regwrite_cond);
  assign pc_en      = rst_n && (ctrl_q.pc_en || pc_en_cond);
  assign illegal_op = rst_n && decode_illegal;
  assign state      = state_q;

endmodule
